flick_debouncer: RTL and testbench
==================================

// Module: flick_debouncer
// PURPOSE
//  Upstream input conditioner for the bound flasher's FLICK input. Takes the raw, asynchronous,
//  bouncing push-button level and synchronises and debounces it.
//  Emits a clean one-CLK-cycle FLICK pulse per debounced press, plus the debounced button level.
//  Sits between the board pin and the flasher's FLICK port, in the same CLK/RST domain.
// PARAMETERS
//  SYNC_STAGES      2    flip-flops in the BTN_RAW synchroniser chain (>=2)
//  DEBOUNCE_CYCLES  16   consecutive stable CLK cycles needed to accept a level change (>=1)
//  REPEAT_DELAY     64   cycles held in PRESSED before the first auto-repeat pulse (FLICK_REPEAT_EN only)
//  REPEAT_PERIOD    16   cycles between subsequent auto-repeat pulses (FLICK_REPEAT_EN only)
// PORTS
//  CLK        in   1  system clock, rising edge
//  RST        in   1  reset: asynchronous, active-low
//  BTN_RAW    in   1  raw button level, active-high, asynchronous to CLK, may bounce
//  FLICK      out  1  registered single-cycle pulse per accepted press (and per repeat)
//  BTN_LEVEL  out  1  debounced button level (registered)
// BEHAVIOUR
//  Reset (RST low, async):
//   - synchroniser chain = 0; state = IDLE; counters = 0; FLICK = 0; BTN_LEVEL = 0.
//   - Outputs stay 0 while RST is low, whatever BTN_RAW does.
//  Sync: BTN_RAW enters sync[0]; sync_q = sync[SYNC_STAGES-1] is the only signal the FSM sees.
//  Counter: cnt, width $clog2(max(DEBOUNCE_CYCLES,REPEAT_DELAY,REPEAT_PERIOD)+1). Saturation is never needed.
//  FSM, evaluated each CLK edge:
//   IDLE         : sync_q=1 -> PRESS_WAIT, cnt<=0.
//   PRESS_WAIT   : sync_q=0 -> IDLE (bounce rejected, no pulse).
//                  cnt==DEBOUNCE_CYCLES-1 -> PRESSED, FLICK<=1, BTN_LEVEL<=1.
//                  Otherwise cnt++.
//   PRESSED      : sync_q=0 -> RELEASE_WAIT, cnt<=0.
//   RELEASE_WAIT : sync_q=1 -> PRESSED (glitch rejected, no pulse, BTN_LEVEL stays 1).
//                  cnt==DEBOUNCE_CYCLES-1 -> IDLE, BTN_LEVEL<=0.
//                  Otherwise cnt++.
//  FLICK is 0 on every edge except the pulse edges above; its width is always exactly 1 cycle.
//  Release never generates FLICK.
//  Latency: E0 is the first edge that samples BTN_RAW high, with BTN_RAW stable from then on.
//   - FLICK and BTN_LEVEL rise after edge E0+SYNC_STAGES+DEBOUNCE_CYCLES (N; default N=18).
//   - Release is symmetric: BTN_LEVEL falls N edges after the first low sample.
//  Any low sample during PRESS_WAIT restarts qualification from IDLE. A press therefore yields
//  exactly one pulse, N edges after the final rising sample.
//  Reset mid-operation: immediate return to reset values; no pending pulse survives.
//  Button held through reset release: treated as a new press; one FLICK after N edges.
// CONFIGURATION
//  FLICK_REPEAT_EN defined:
//   - On each entry to PRESSED (edge P), an auto-repeat timer starts from 0.
//   - Extra FLICK pulses fire after edges P+REPEAT_DELAY, then every REPEAT_PERIOD edges.
//   - Pulses continue while the FSM stays in PRESSED.
//   - Leaving PRESSED stops repeats. Re-entry from RELEASE_WAIT restarts the delay and
//     emits no immediate pulse.
//  FLICK_REPEAT_EN undefined:
//   - No repeat logic is synthesised; REPEAT_* are ignored.
//   - Exactly one FLICK per debounced press.
// TESTING (defaults unless stated)
//  1 RST low 10 cycles with BTN_RAW=1 -> FLICK=0, BTN_LEVEL=0 throughout;
//    after RST rises, one FLICK 18 edges after the first high sample.
//  2 Clean press: BTN_RAW 0->1 held 50 cycles, then 0 -> single 1-cycle FLICK at E0+18;
//    BTN_LEVEL 1 from E0+18; BTN_LEVEL falls 18 edges after the release sample; no second FLICK.
//  3 Bounce: BTN_RAW toggles every 3 cycles for 30 cycles, then stays 1 -> exactly one FLICK,
//    18 edges after the last rising sample.
//  4 Release glitch: while pressed, BTN_RAW=0 for 5 cycles, then 1 -> BTN_LEVEL stays 1, no FLICK.
//  5 Reset mid-debounce: RST low when cnt=10 in PRESS_WAIT -> FLICK never pulses for that attempt;
//    FSM in IDLE; outputs 0.
//  6 FLICK_REPEAT_EN, hold 120 cycles past PRESSED entry P -> FLICK at P, P+64, P+80, P+96, P+112.
//    Same stimulus with the macro undefined -> FLICK at P only.

Source files
------------

// File: rtl/flick_debouncer.sv
// Synchronises and debounces the raw FLICK push-button, emitting one-cycle FLICK pulses
// and the debounced level. Optional auto-repeat while held: define FLICK_REPEAT_EN.
module flick_debouncer #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_DELAY    = 64,
  parameter int unsigned REPEAT_PERIOD   = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic BTN_RAW,
  output logic FLICK,
  output logic BTN_LEVEL
);

  localparam int unsigned MAX_DR  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int unsigned CNT_MAX = (MAX_DR > REPEAT_PERIOD) ? MAX_DR : REPEAT_PERIOD;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_q;

  assign sync_q = sync[SYNC_STAGES-1];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], BTN_RAW};
    end
  end

`ifdef FLICK_REPEAT_EN
  localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);

  // Set once the initial repeat delay has elapsed; later pulses use the period.
  logic rep_phase;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      cnt       <= '0;
      FLICK     <= 1'b0;
      BTN_LEVEL <= 1'b0;
      rep_phase <= 1'b0;
    end else begin
      FLICK <= 1'b0;
      case (state)
        IDLE: begin
          if (sync_q) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!sync_q) begin
            state <= IDLE;
          end else if (cnt == DB_LAST) begin
            state     <= PRESSED;
            FLICK     <= 1'b1;
            BTN_LEVEL <= 1'b1;
            cnt       <= '0;
            rep_phase <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED: begin
          // The same counter times repeats here; leaving PRESSED wins over a due repeat.
          if (!sync_q) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end else if (cnt == (rep_phase ? RP_LAST : RD_LAST)) begin
            FLICK     <= 1'b1;
            cnt       <= '0;
            rep_phase <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RELEASE_WAIT: begin
          if (sync_q) begin
            state     <= PRESSED;
            cnt       <= '0;
            rep_phase <= 1'b0;
          end else if (cnt == DB_LAST) begin
            state     <= IDLE;
            BTN_LEVEL <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      cnt       <= '0;
      FLICK     <= 1'b0;
      BTN_LEVEL <= 1'b0;
    end else begin
      FLICK <= 1'b0;
      case (state)
        IDLE: begin
          if (sync_q) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!sync_q) begin
            state <= IDLE;
          end else if (cnt == DB_LAST) begin
            state     <= PRESSED;
            FLICK     <= 1'b1;
            BTN_LEVEL <= 1'b1;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!sync_q) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (sync_q) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            state     <= IDLE;
            BTN_LEVEL <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_flick_debouncer.sv
// Bench for flick_debouncer: expected FLICK edges are queued when stimulus is driven and
// matched against observed pulses; level checks come from a vector table and hand sequences.
module tb_flick_debouncer;

  localparam int N = 18;  // SYNC_STAGES + DEBOUNCE_CYCLES at defaults

  logic clk;
  logic rst;
  logic btn_raw;
  logic flick;
  logic btn_level;

  flick_debouncer #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(16),
    .REPEAT_DELAY   (64),
    .REPEAT_PERIOD  (16)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .BTN_RAW  (btn_raw),
    .FLICK    (flick),
    .BTN_LEVEL(btn_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;
  int exp_q[$];

  task automatic check(input bit ok, input string name, input int act, input int req);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // Every observed pulse must match the oldest expected pulse edge.
  always @(negedge clk) begin
    if (flick === 1'b1) begin
      if (exp_q.size() == 0) begin
        check(1'b0, "unexpected_flick", cyc, -1);
      end else begin
        int e;
        e = exp_q.pop_front();
        check(cyc == e, "flick_edge", cyc, e);
      end
    end
  end

  task automatic queue_empty(input string name);
    check(exp_q.size() == 0, name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic drive_hold(input logic v, input int n);
    btn_raw = v;
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic btn;
    int   cycles;
    int   flick_off;  // pulse edge relative to first sample of the row, -1 for none
    logic level;      // BTN_LEVEL after the last edge of the row
  } vec_t;

  vec_t vecs[12];

  initial begin
    int s;
    vecs[0]  = '{1'b0, 20, -1, 1'b0};
    vecs[1]  = '{1'b1, 50, N,  1'b1};  // clean press
    vecs[2]  = '{1'b0, 30, -1, 1'b0};  // release, no pulse
    vecs[3]  = '{1'b1, 30, N,  1'b1};
    vecs[4]  = '{1'b0, 5,  -1, 1'b1};  // release glitch
    vecs[5]  = '{1'b1, 30, -1, 1'b1};  // glitch rejected, no pulse
    vecs[6]  = '{1'b0, 30, -1, 1'b0};
    vecs[7]  = '{1'b1, 10, -1, 1'b0};  // too short
    vecs[8]  = '{1'b0, 30, -1, 1'b0};
    vecs[9]  = '{1'b1, 17, N,  1'b0};  // shortest accepted press; pulse lands in next row
    vecs[10] = '{1'b0, 30, -1, 1'b0};
    vecs[11] = '{1'b1, 16, -1, 1'b0};  // one sample short

    // Reset held with button high: outputs stay low
    rst = 1'b0;
    btn_raw = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check(flick == 1'b0 && btn_level == 1'b0, "reset_outputs", {flick, btn_level}, 0);
    end
    rst = 1'b1;
    s = cyc + 1;
    exp_q.push_back(s + N);
    repeat (N) @(negedge clk);
    check(btn_level == 1'b0, "level_before_N", btn_level, 0);
    @(negedge clk);
    check(btn_level == 1'b1, "level_at_N", btn_level, 1);
    repeat (20) @(negedge clk);
    s = cyc + 1;
    btn_raw = 1'b0;
    repeat (N) @(negedge clk);
    check(btn_level == 1'b1, "release_level_before_N", btn_level, 1);
    @(negedge clk);
    check(btn_level == 1'b0, "release_level_at_N", btn_level, 0);
    repeat (10) @(negedge clk);
    queue_empty("reset_press_pulses");

    // Vector table
    for (int i = 0; i < 12; i++) begin
      s = cyc + 1;
      if (vecs[i].flick_off >= 0) exp_q.push_back(s + vecs[i].flick_off);
      drive_hold(vecs[i].btn, vecs[i].cycles);
      check(btn_level == vecs[i].level, $sformatf("vec%0d_level", i), btn_level, vecs[i].level);
    end
    drive_hold(1'b0, 30);
    queue_empty("vector_pulses");

    // Bounce: toggle every 3 cycles for 30 cycles, then hold high
    s = cyc + 1;
    for (int i = 0; i < 30; i++) drive_hold(((i / 3) % 2) == 0, 1);
    exp_q.push_back(s + 30 + N);
    drive_hold(1'b1, 40);
    check(btn_level == 1'b1, "bounce_level", btn_level, 1);
    drive_hold(1'b0, 30);
    queue_empty("bounce_pulses");

    // Reset while counting in PRESS_WAIT (cnt reaches 10 after edge s+12)
    s = cyc + 1;
    drive_hold(1'b1, 13);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check(flick == 1'b0 && btn_level == 1'b0, "midreset_outputs", {flick, btn_level}, 0);
    end
    btn_raw = 1'b0;
    rst = 1'b1;
    repeat (30) @(negedge clk);
    check(btn_level == 1'b0, "midreset_level", btn_level, 0);
    queue_empty("midreset_pulses");

    // Long hold: 120 cycles past PRESSED entry
    s = cyc + 1;
    exp_q.push_back(s + N);
`ifdef FLICK_REPEAT_EN
    exp_q.push_back(s + N + 64);
    exp_q.push_back(s + N + 80);
    exp_q.push_back(s + N + 96);
    exp_q.push_back(s + N + 112);
`endif
    drive_hold(1'b1, N + 120);
    check(btn_level == 1'b1, "hold_level", btn_level, 1);
    drive_hold(1'b0, 30);
    check(btn_level == 1'b0, "hold_release_level", btn_level, 0);
    queue_empty("hold_pulses");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
